// File: rtl/pic_host_sequencer_if.sv
// PIC 8259A bus and CPU vector handshake bundle.
// master = sequencer side, slave = PIC/CPU environment side.
interface pic_host_sequencer_if;
  logic       pic_int;
  logic [7:0] data_in;
  logic       cs_neg;
  logic       wr_neg;
  logic       rd_neg;
  logic       a0;
  logic       inta_neg;
  logic [7:0] data_out;
  logic       data_oe;
  logic       init_done;
  logic       vec_valid;
  logic [7:0] vec_data;
  logic       vec_ready;

  modport master (
    input  pic_int, data_in, vec_ready,
    output cs_neg, wr_neg, rd_neg, a0, inta_neg,
    output data_out, data_oe, init_done,
    output vec_valid, vec_data
  );

  modport slave (
    output pic_int, data_in, vec_ready,
    input  cs_neg, wr_neg, rd_neg, a0, inta_neg,
    input  data_out, data_oe, init_done,
    input  vec_valid, vec_data
  );
endinterface

// File: rtl/pic_host_sequencer.sv
// Host-side sequencer for an 8259A PIC: init writes,
// two-pulse INTA vector fetch, and non-specific EOI.
module pic_host_sequencer #(
  parameter logic [4:0]  VECTOR_BASE = 5'b01000,
  parameter bit          SINGLE      = 1'b1,
  parameter bit          LEVEL       = 1'b0,
  parameter bit          AEOI        = 1'b0,
  parameter logic [7:0]  ICW3_VAL    = 8'h00,
  parameter logic [7:0]  IMR_INIT    = 8'h00,
  parameter int unsigned PULSE_W     = 2,
  parameter int unsigned GAP_W       = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  pic_host_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_READY = 3'd2;
  localparam logic [2:0] S_INTA1 = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_INTA2 = 3'd5;
  localparam logic [2:0] S_VEC   = 3'd6;
  localparam logic [2:0] S_EOI   = 3'd7;

  localparam logic [1:0] P_SETUP = 2'd0;
  localparam logic [1:0] P_STRB  = 2'd1;
  localparam logic [1:0] P_HOLD  = 2'd2;

  localparam logic [7:0] PW_M1 = 8'(PULSE_W - 1);
  localparam logic [7:0] GW_M1 = 8'(GAP_W - 1);
  localparam logic [2:0] LAST  = SINGLE ? 3'd3 : 3'd4;

  localparam logic [7:0] ICW1 =
    {3'b000, 1'b1, LEVEL, 1'b0, SINGLE, 1'b1};
  localparam logic [7:0] ICW2 = {VECTOR_BASE, 3'b000};
  localparam logic [7:0] ICW4 = {6'b0, AEOI, 1'b1};
  localparam logic [7:0] OCW2 = 8'h20;

  logic [2:0] r_state;
  logic [1:0] r_ph;
  logic [2:0] r_idx;
  logic [7:0] r_cnt;
  logic       r_s1;
  logic       r_s2;
  logic       r_init_done;
  logic [7:0] r_vec;

  logic       w_bus;
  logic       w_a0;
  logic [7:0] w_byte;

  assign w_bus = (r_state == S_INIT) || (r_state == S_EOI);

  // ICW3 only exists in cascade mode, so later slots shift.
  always_comb begin
    w_a0   = 1'b0;
    w_byte = 8'h00;
    if (r_state == S_EOI) begin
      w_byte = OCW2;
    end else if (r_state == S_INIT) begin
      case (r_idx)
        3'd0: w_byte = ICW1;
        3'd1: begin w_a0 = 1'b1; w_byte = ICW2; end
        3'd2: begin
          w_a0   = 1'b1;
          w_byte = SINGLE ? ICW4 : ICW3_VAL;
        end
        3'd3: begin
          w_a0   = 1'b1;
          w_byte = SINGLE ? IMR_INIT : ICW4;
        end
        default: begin w_a0 = 1'b1; w_byte = IMR_INIT; end
      endcase
    end
  end

  assign bus.cs_neg    = ~w_bus;
  assign bus.wr_neg    = ~(w_bus && (r_ph == P_STRB));
  assign bus.rd_neg    = 1'b1;
  assign bus.data_oe   = w_bus;
  assign bus.a0        = w_a0;
  assign bus.data_out  = w_byte;
  assign bus.inta_neg  = ~((r_state == S_INTA1) ||
                           (r_state == S_INTA2));
  assign bus.init_done = r_init_done;
  assign bus.vec_valid = (r_state == S_VEC);
  assign bus.vec_data  = r_vec;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ph        <= P_SETUP;
      r_idx       <= 3'd0;
      r_cnt       <= 8'd0;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_init_done <= 1'b0;
      r_vec       <= 8'h00;
    end else begin
      r_s1 <= bus.pic_int;
      r_s2 <= r_s1;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_INIT;
            r_idx   <= 3'd0;
            r_ph    <= P_SETUP;
          end
        end
        S_INIT, S_EOI: begin
          case (r_ph)
            P_SETUP: begin
              r_ph  <= P_STRB;
              r_cnt <= 8'd0;
            end
            P_STRB: begin
              if (r_cnt == PW_M1) r_ph <= P_HOLD;
              else r_cnt <= r_cnt + 8'd1;
            end
            default: begin
              r_ph <= P_SETUP;
              if (r_state == S_EOI) begin
                r_state <= S_READY;
              end else if (r_idx == LAST) begin
                r_state     <= S_READY;
                r_init_done <= 1'b1;
              end else begin
                r_idx <= r_idx + 3'd1;
              end
            end
          endcase
        end
        S_READY: begin
          if (i_start) begin
            r_state     <= S_INIT;
            r_idx       <= 3'd0;
            r_ph        <= P_SETUP;
            r_init_done <= 1'b0;
          end else if (r_s2) begin
            r_state <= S_INTA1;
            r_cnt   <= 8'd0;
          end
        end
        S_INTA1: begin
          if (r_cnt == PW_M1) begin
            r_state <= S_GAP;
            r_cnt   <= 8'd0;
          end else r_cnt <= r_cnt + 8'd1;
        end
        S_GAP: begin
          if (r_cnt == GW_M1) begin
            r_state <= S_INTA2;
            r_cnt   <= 8'd0;
          end else r_cnt <= r_cnt + 8'd1;
        end
        S_INTA2: begin
          if (r_cnt == PW_M1) begin
            r_vec   <= bus.data_in;
            r_state <= S_VEC;
          end else r_cnt <= r_cnt + 8'd1;
        end
        S_VEC: begin
          if (bus.vec_ready) begin
            r_state <= AEOI ? S_READY : S_EOI;
            r_ph    <= P_SETUP;
          end
        end
      endcase
    end
  end

endmodule
